// File: rtl/maze_pkg.sv
// Shared move encoding, error codes and replayer states for the maze solver and path checker.
`default_nettype none

package maze_pkg;

  localparam logic [1:0] MOVE_XP = 2'b00;
  localparam logic [1:0] MOVE_YP = 2'b01;
  localparam logic [1:0] MOVE_XM = 2'b10;
  localparam logic [1:0] MOVE_YM = 2'b11;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_BOUNDS = 2'b01;
  localparam logic [1:0] ERR_WALL   = 2'b10;
  localparam logic [1:0] ERR_STREAM = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_MOVE = 3'd1,
    CHECK     = 3'd2,
    EVAL      = 3'd3,
    DONE      = 3'd4,
    ERROR     = 3'd5
  } replay_state_t;

endpackage

`default_nettype wire

// File: rtl/maze_path_replayer_if.sv
// Move-stream handshake and wall-map read port between the replayer and its environment.
`default_nettype none

interface maze_path_replayer_if;
  import maze_pkg::*;

  logic       move_valid;
  logic [1:0] move_in;
  logic       move_ready;
  logic       stream_end;
  logic       map_rd;
  logic [7:0] map_addr;
  logic       map_data;

  modport master (
    output move_valid, move_in, stream_end, map_data,
    input  move_ready, map_rd, map_addr
  );

  modport slave (
    input  move_valid, move_in, stream_end, map_data,
    output move_ready, map_rd, map_addr
  );

endinterface

`default_nettype wire

// File: rtl/maze_path_replayer_pos_stepper.sv
// Applies one move code to a 4-bit X/Y position and flags leaving the 16x16 grid.
`default_nettype none

module pos_stepper
  import maze_pkg::*;
(
  input  logic [3:0] cur_x,
  input  logic [3:0] cur_y,
  input  logic [1:0] move,
  output logic [3:0] cand_x,
  output logic [3:0] cand_y,
  output logic       out_of_bounds
);

  logic [4:0] sum_x;
  logic [4:0] sum_y;

  // The fifth bit catches both carry past 15 and borrow below 0.
  always_comb begin
    sum_x = {1'b0, cur_x};
    sum_y = {1'b0, cur_y};
    case (move)
      MOVE_XP: sum_x = {1'b0, cur_x} + 5'd1;
      MOVE_YP: sum_y = {1'b0, cur_y} + 5'd1;
      MOVE_XM: sum_x = {1'b0, cur_x} - 5'd1;
      MOVE_YM: sum_y = {1'b0, cur_y} - 5'd1;
      default: ;
    endcase
    cand_x        = sum_x[3:0];
    cand_y        = sum_y[3:0];
    out_of_bounds = sum_x[4] | sum_y[4];
  end

endmodule

`default_nettype wire

// File: rtl/maze_path_replayer.sv
// Replays a move stream from the start cell over a walled 16x16 maze and reports goal or error.
`default_nettype none

module maze_path_replayer
  import maze_pkg::*;
#(
  parameter logic [3:0] START_X = 4'd0,
  parameter logic [3:0] START_Y = 4'd15,
  parameter logic [3:0] GOAL_X  = 4'd15,
  parameter logic [3:0] GOAL_Y  = 4'd0
) (
  input  logic                        Clk,
  input  logic                        our_reset,
  input  logic                        start,
  maze_path_replayer_if.slave         link,
  output logic [3:0]                  X,
  output logic [3:0]                  Y,
  output logic [7:0]                  step_count,
  output logic                        done,
  output logic                        error,
  output logic [1:0]                  err_code
);

  localparam logic [7:0] GOAL_CELL     = {GOAL_Y, GOAL_X};
  localparam logic       START_AT_GOAL = ({START_Y, START_X} == GOAL_CELL);

  replay_state_t state, state_nx;
  logic [3:0] cand_x, cand_y, cand_x_nx, cand_y_nx, x_nx, y_nx;
  logic [3:0] step_x, step_y;
  logic       step_oob;
  logic [7:0] step_nx, addr_q, addr_nx;
  logic       done_nx, error_nx;
  logic [1:0] err_nx;

  pos_stepper u_stepper (
    .cur_x         (X),
    .cur_y         (Y),
    .move          (link.move_in),
    .cand_x        (step_x),
    .cand_y        (step_y),
    .out_of_bounds (step_oob)
  );

  assign link.move_ready = (state == WAIT_MOVE);
  assign link.map_rd     = (state == CHECK);
  assign link.map_addr   = addr_q;

  always_comb begin
    state_nx  = state;
    x_nx      = X;
    y_nx      = Y;
    cand_x_nx = cand_x;
    cand_y_nx = cand_y;
    step_nx   = step_count;
    addr_nx   = addr_q;
    done_nx   = done;
    error_nx  = error;
    err_nx    = err_code;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          x_nx     = START_X;
          y_nx     = START_Y;
          step_nx  = 8'd0;
          error_nx = 1'b0;
          err_nx   = ERR_NONE;
          done_nx  = START_AT_GOAL;
          state_nx = START_AT_GOAL ? DONE : WAIT_MOVE;
        end
      end
      WAIT_MOVE: begin
        // A pending move wins over end-of-stream in the same cycle.
        if (link.move_valid) begin
          if (step_oob) begin
            state_nx = ERROR;
            error_nx = 1'b1;
            err_nx   = ERR_BOUNDS;
          end else begin
            cand_x_nx = step_x;
            cand_y_nx = step_y;
            addr_nx   = {step_y, step_x};
            state_nx  = CHECK;
          end
        end else if (link.stream_end) begin
          state_nx = ERROR;
          error_nx = 1'b1;
          err_nx   = ERR_STREAM;
        end
      end
      CHECK: state_nx = EVAL;
      EVAL: begin
        if (link.map_data) begin
          state_nx = ERROR;
          error_nx = 1'b1;
          err_nx   = ERR_WALL;
        end else begin
          x_nx    = cand_x;
          y_nx    = cand_y;
          step_nx = (step_count == 8'hFF) ? step_count : step_count + 8'd1;
          if ({cand_y, cand_x} == GOAL_CELL) begin
            state_nx = DONE;
            done_nx  = 1'b1;
          end else begin
            state_nx = WAIT_MOVE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge our_reset) begin
    if (our_reset) begin
      state      <= IDLE;
      X          <= START_X;
      Y          <= START_Y;
      cand_x     <= 4'd0;
      cand_y     <= 4'd0;
      step_count <= 8'd0;
      addr_q     <= 8'd0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      state      <= state_nx;
      X          <= x_nx;
      Y          <= y_nx;
      cand_x     <= cand_x_nx;
      cand_y     <= cand_y_nx;
      step_count <= step_nx;
      addr_q     <= addr_nx;
      done       <= done_nx;
      error      <= error_nx;
      err_code   <= err_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_maze_path_replayer.sv
// Directed bench for maze_path_replayer: queue-fed move source plus a registered wall-map model.
`default_nettype none

module tb_maze_path_replayer;
  import maze_pkg::*;

  logic       Clk = 1'b0;
  logic       our_reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] X, Y;
  logic [7:0] step_count;
  logic       done, error;
  logic [1:0] err_code;

  maze_path_replayer_if link();

  maze_path_replayer dut (
    .Clk        (Clk),
    .our_reset  (our_reset),
    .start      (start),
    .link       (link),
    .X          (X),
    .Y          (Y),
    .step_count (step_count),
    .done       (done),
    .error      (error),
    .err_code   (err_code)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Wall map with one-cycle read latency; also logs reads and counts edges.
  logic [255:0] walls = '0;
  int           map_rd_cnt = 0;
  logic [7:0]   last_addr = 8'h00;
  int           cyc = 0;

  always @(posedge Clk) begin
    link.map_data <= link.map_rd ? walls[link.map_addr] : 1'b0;
    if (link.map_rd) begin
      map_rd_cnt <= map_rd_cnt + 1;
      last_addr  <= link.map_addr;
    end
    cyc <= cyc + 1;
  end

  // Move source: presents q[0]; a transfer is due when valid and ready are both high at the negedge.
  logic [1:0] q[$];
  bit src_en = 0, end_flag = 0, force_end = 0, took = 0;
  int accepts = 0;
  int first_acc = 0;

  initial begin
    link.move_valid = 1'b0;
    link.move_in    = 2'b00;
    link.stream_end = 1'b0;
    forever begin
      @(negedge Clk);
      if (took && q.size() > 0) begin
        void'(q.pop_front());
        if (accepts == 0) first_acc = cyc;
        accepts++;
      end
      link.move_valid = src_en && (q.size() > 0);
      link.move_in    = link.move_valid ? q[0] : 2'b00;
      link.stream_end = src_en && ((end_flag && q.size() == 0) || force_end);
      took            = link.move_valid && link.move_ready;
    end
  end

  task automatic pulse_start();
    @(negedge Clk);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      #1;
      if (done || error) break;
    end
    check("end_reached", {31'd0, done | error}, 32'd1);
  endtask

  task automatic load_path();
    q.delete();
    for (int i = 0; i < 15; i++) q.push_back(MOVE_XP);
    for (int i = 0; i < 15; i++) q.push_back(MOVE_YM);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_x"}, X, 4'd0);
    check({pfx, "_y"}, Y, 4'd15);
    check({pfx, "_steps"}, step_count, 8'd0);
    check({pfx, "_ready"}, link.move_ready, 1'b0);
    check({pfx, "_map_rd"}, link.map_rd, 1'b0);
    check({pfx, "_map_addr"}, link.map_addr, 8'h00);
    check({pfx, "_done"}, done, 1'b0);
    check({pfx, "_error"}, error, 1'b0);
    check({pfx, "_err_code"}, err_code, 2'b00);
  endtask

  int base;

  initial begin
    repeat (3) @(negedge Clk);
    #1;
    check_reset_values("rst");
    @(negedge Clk);
    our_reset = 1'b0;

    // First move X-1 from column 0 leaves the grid without touching the map.
    q = {MOVE_XM}; src_en = 1; accepts = 0; base = map_rd_cnt;
    pulse_start();
    wait_end(20);
    check("oob_error", error, 1'b1);
    check("oob_code", err_code, ERR_BOUNDS);
    check("oob_x", X, 4'd0);
    check("oob_y", Y, 4'd15);
    check("oob_steps", step_count, 8'd0);
    check("oob_no_map_rd", map_rd_cnt - base, 0);
    src_en = 0; q.delete();

    // Wall directly right of the start cell.
    walls[8'hF1] = 1'b1;
    q = {MOVE_XP}; src_en = 1; base = map_rd_cnt;
    pulse_start();
    wait_end(20);
    check("wall_rd_cnt", map_rd_cnt - base, 1);
    check("wall_addr", last_addr, 8'hF1);
    check("wall_error", error, 1'b1);
    check("wall_code", err_code, ERR_WALL);
    check("wall_x", X, 4'd0);
    check("wall_steps", step_count, 8'd0);
    walls = '0; src_en = 0; q.delete();

    // Stream runs dry after three moves, short of the goal.
    q = {MOVE_XP, MOVE_XP, MOVE_XP}; end_flag = 1; src_en = 1;
    pulse_start();
    wait_end(40);
    check("end_error", error, 1'b1);
    check("end_code", err_code, ERR_STREAM);
    check("end_steps", step_count, 8'd3);
    check("end_x", X, 4'd3);
    check("end_done", done, 1'b0);
    src_en = 0; end_flag = 0; q.delete();

    // Full path: accepts every 3 cycles, last commit 2 edges after the 30th accept.
    load_path(); accepts = 0; src_en = 1;
    pulse_start();
    wait_end(200);
    check("path_done", done, 1'b1);
    check("path_error", error, 1'b0);
    check("path_x", X, 4'd15);
    check("path_y", Y, 4'd0);
    check("path_steps", step_count, 8'd30);
    check("path_accepts", accepts, 30);
    check("path_latency", cyc - first_acc, 89);
    check("path_ready_after", link.move_ready, 1'b0);
    src_en = 0;

    // Asynchronous reset landing in the CHECK cycle of move 5.
    load_path(); accepts = 0; src_en = 1;
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      #1;
      if (accepts == 5 && link.map_rd) break;
    end
    check("mid_in_check5", {31'd0, accepts == 5 && link.map_rd}, 32'd1);
    check("mid_x_before", X, 4'd4);
    our_reset = 1'b1; src_en = 0; q.delete();
    #1;
    check_reset_values("mid");
    @(negedge Clk);
    our_reset = 1'b0;
    load_path(); src_en = 1;
    pulse_start();
    wait_end(200);
    check("rerun_done", done, 1'b1);
    check("rerun_steps", step_count, 8'd30);
    src_en = 0;

    // Start pulses in WAIT_MOVE and in EVAL must not restart the replay.
    q = {MOVE_XP}; src_en = 1;
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      #1;
      if (step_count == 8'd1) break;
    end
    pulse_start();
    repeat (2) @(negedge Clk);
    #1;
    check("ign_wait_x", X, 4'd1);
    check("ign_wait_steps", step_count, 8'd1);
    check("ign_wait_ready", link.move_ready, 1'b1);
    for (int i = 0; i < 14; i++) q.push_back(MOVE_XP);
    for (int i = 0; i < 15; i++) q.push_back(MOVE_YM);
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      #1;
      if (link.map_rd) break;
    end
    check("ign_in_check", link.map_rd, 1'b1);
    @(negedge Clk);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    #1;
    check("ign_eval_x", X, 4'd2);
    check("ign_eval_steps", step_count, 8'd2);
    wait_end(200);
    check("ign_done", done, 1'b1);
    check("ign_steps", step_count, 8'd30);
    src_en = 0;

    // move_valid and stream_end together: the move is taken first.
    q = {MOVE_XP}; force_end = 1; src_en = 1;
    pulse_start();
    wait_end(30);
    check("prio_code", err_code, ERR_STREAM);
    check("prio_steps", step_count, 8'd1);
    check("prio_x", X, 4'd1);
    src_en = 0; force_end = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
